// File: rtl/therm_step_driver.sv
// Binary-to-thermometer driver that walks therm_out one level per clock toward the
// requested code, then holds for a settle window before accepting the next code.
module therm_step_driver #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code_in,
    input  logic       code_valid,
    output logic       code_ready,
    output logic [7:0] therm_out,
    output logic [2:0] level,
    output logic       settled,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        SETTLE
    } state_t;

    state_t           state;
    logic [2:0]       target;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       step_level;

    function automatic logic [7:0] therm_of(input logic [2:0] lvl);
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            t[i] = (3'(i) <= lvl);
        end
        return t;
    endfunction

    // One level toward target; STEP is only entered with target != level, so no wrap.
    assign step_level = (target > level) ? level + 3'd1 : level - 3'd1;

    // NOTE: every register here uses <= so all state updates see the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            target     <= '0;
            cnt        <= '0;
            level      <= '0;
            therm_out  <= 8'h01;
            code_ready <= 1'b1;
            settled    <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (code_valid && code_ready && (code_in != level)) begin
                        target     <= code_in;
                        settled    <= 1'b0;
                        code_ready <= 1'b0;
                        busy       <= 1'b1;
                        state      <= STEP;
                    end
                end
                STEP: begin
                    level     <= step_level;
                    therm_out <= therm_of(step_level);
                    if (step_level == target) begin
                        cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        settled    <= 1'b1;
                        code_ready <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_therm_step_driver.sv
// Self-checking bench for therm_step_driver: a trajectory model (start level, target,
// accept edge) predicts every output from edge arithmetic alone.
module tb_therm_step_driver;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] code_in = '0;
    logic       code_valid = 1'b0;
    logic       code_ready;
    logic [7:0] therm_out;
    logic [2:0] level;
    logic       settled;
    logic       busy;

    therm_step_driver #(.SETTLE_CYCLES(S), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .therm_out  (therm_out),
        .level      (level),
        .settled    (settled),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: the last move started at edge m_e0 from m_from toward m_to.
    int edge_n = 0;
    int m_from = 0;
    int m_to   = 0;
    int m_e0   = 0;
    bit took;
    logic [2:0] exp_level;
    logic [7:0] exp_therm;
    logic       exp_ready;

    function automatic int m_dist();
        return (m_to > m_from) ? m_to - m_from : m_from - m_to;
    endfunction

    function automatic int m_lvl(input int e);
        int k, st;
        k  = e - m_e0;
        st = (k < m_dist()) ? k : m_dist();
        return (m_to >= m_from) ? m_from + st : m_from - st;
    endfunction

    function automatic bit m_rdy(input int e);
        return (m_dist() == 0) || ((e - m_e0) >= m_dist() + S);
    endfunction

    function automatic logic [7:0] therm_ref(input int l);
        int t;
        t = (1 << (l + 1)) - 1;
        return t[7:0];
    endfunction

    function automatic int prio_enc(input logic [7:0] t);
        int e;
        e = -1;
        for (int i = 0; i < 8; i++) if (t[i] === 1'b1) e = i;
        return e;
    endfunction

    function automatic bit outputs_ok();
        return (level === exp_level) && (therm_out === exp_therm) && (code_ready === exp_ready)
            && (settled === exp_ready) && (busy === ~exp_ready);
    endfunction

    task automatic model_eval();
        exp_level = 3'(m_lvl(edge_n));
        exp_therm = therm_ref(m_lvl(edge_n));
        exp_ready = m_rdy(edge_n);
    endtask

    task automatic model_reset();
        m_from = 0;
        m_to   = 0;
        m_e0   = edge_n;
        model_eval();
    endtask

    // One rising edge; the model applies the accept rule using pre-edge readiness.
    task automatic advance();
        bit rdy;
        int l;
        rdy = m_rdy(edge_n);
        l   = m_lvl(edge_n);
        @(posedge clk);
        edge_n++;
        took = 1'b0;
        if (code_valid && rdy) begin
            took = 1'b1;
            if (int'(code_in) != l) begin
                m_from = l;
                m_to   = int'(code_in);
                m_e0   = edge_n;
            end
        end
        #1;
        model_eval();
    endtask

    task automatic report(input string name);
        $display("FAIL %s edge %0d: level=%0d therm=%h ready=%b settled=%b busy=%b, expected level=%0d therm=%h ready=%b",
                 name, edge_n, level, therm_out, code_ready, settled, busy, exp_level, exp_therm, exp_ready);
    endtask

    task automatic test_reset();
        code_in = 3'd6; code_valid = 1'b1;
        advance();
        code_valid = 1'b0;
        advance();
        advance();
        checks++;
        if (level !== 3'd2) begin
            errors++;
            $display("FAIL reset_pre level=%0d expected 2", level);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({therm_out, level, code_ready, settled, busy} !== {8'h01, 3'd0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_async therm=%h level=%0d ready=%b settled=%b busy=%b, expected 01 0 1 1 0",
                     therm_out, level, code_ready, settled, busy);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_up_step();
        int low;
        code_in = 3'd5; code_valid = 1'b1;
        advance();
        code_valid = 1'b0;
        low = code_ready ? 0 : 1;
        for (int i = 1; i <= 12; i++) begin
            advance();
            if (!code_ready) low++;
            checks++;
            if (!outputs_ok()) begin errors++; report("up_step"); end
            if (i == 5) begin
                checks++;
                if (therm_out !== 8'h3F) begin
                    errors++;
                    $display("FAIL up_step_target therm=%h expected 3f", therm_out);
                end
            end
        end
        checks++;
        if (low != 9) begin
            errors++;
            $display("FAIL up_step_ready_low low_cycles=%0d expected 9", low);
        end
    endtask

    task automatic test_down_step();
        logic [7:0] seq [6] = '{8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07};
        code_in = 3'd7; code_valid = 1'b1;
        advance();
        code_valid = 1'b0;
        for (int i = 0; i < 12 && !code_ready; i++) advance();
        code_in = 3'd2; code_valid = 1'b1;
        advance();
        code_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (therm_out !== seq[i] || !outputs_ok()) begin
                errors++;
                $display("FAIL down_step step %0d therm=%h expected %h", i, therm_out, seq[i]);
            end
            advance();
        end
        for (int i = 0; i < 8 && !code_ready; i++) advance();
        code_in = 3'd2; code_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            advance();
            checks++;
            if (code_ready !== 1'b1 || settled !== 1'b1 || therm_out !== 8'h07 || !outputs_ok()) begin
                errors++;
                report("noop_accept");
            end
        end
        code_valid = 1'b0;
    endtask

    task automatic test_held_valid();
        int peak;
        bit got6;
        code_in = 3'd4; code_valid = 1'b1;
        advance();
        code_valid = 1'b0;
        advance(); advance(); advance();
        code_in = 3'd6; code_valid = 1'b1;
        got6 = 1'b0;
        for (int i = 0; i < 20 && !got6; i++) begin
            advance();
            got6 = took;
            checks++;
            if (!outputs_ok()) begin errors++; report("held_six"); end
        end
        code_in = 3'd1;
        peak = level;
        for (int i = 0; i < 30 && code_valid; i++) begin
            advance();
            if (took) code_valid = 1'b0;
            if (int'(level) > peak) peak = level;
            checks++;
            if (!outputs_ok()) begin errors++; report("held_one"); end
        end
        for (int i = 0; i < 20 && !code_ready; i++) advance();
        checks++;
        if (peak != 6 || level !== 3'd1 || !got6) begin
            errors++;
            $display("FAIL held_valid peak=%0d final=%0d accepted6=%b expected 6 1 1", peak, level, got6);
        end
    endtask

    task automatic test_reset_mid_step();
        #3 rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        code_in = 3'd7; code_valid = 1'b1;
        advance();
        code_valid = 1'b0;
        for (int i = 0; i < 10 && level !== 3'd3; i++) advance();
        checks++;
        if (level !== 3'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_step_reach level=%0d busy=%b expected 3 1", level, busy);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({therm_out, level, code_ready, settled, busy} !== {8'h01, 3'd0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mid_step_reset therm=%h level=%0d ready=%b expected 01 0 1", therm_out, level, code_ready);
        end
        rst = 1'b0;
        model_reset();
        code_in = 3'd4; code_valid = 1'b1;
        advance();
        code_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            advance();
            checks++;
            if (!outputs_ok()) begin errors++; report("after_reset_step"); end
        end
        checks++;
        if (level !== 3'd4 || code_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_reset_final level=%0d ready=%b expected 4 1", level, code_ready);
        end
    endtask

    task automatic test_random();
        int exp_low, low;
        logic [7:0] prev;
        exp_low = 0;
        low     = 0;
        prev    = therm_out;
        for (int i = 0; i < 500; i++) begin
            if (!code_valid) begin
                code_in = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 3) != 0) code_valid = 1'b1;
            end
            advance();
            if (took) begin
                code_valid = 1'b0;
                if (m_e0 == edge_n) begin
                    exp_low = m_dist() + S;
                    low     = 0;
                end
            end
            if (!code_ready) low++;
            else if (exp_low != 0) begin
                checks++;
                if (low != exp_low) begin
                    errors++;
                    $display("FAIL rand_ready_low edge %0d low_cycles=%0d expected %0d", edge_n, low, exp_low);
                end
                exp_low = 0;
            end
            checks++;
            if (!outputs_ok()) begin errors++; report("rand_model"); end
            checks++;
            if (prio_enc(therm_out) != int'(level)) begin
                errors++;
                $display("FAIL rand_loopback edge %0d enc=%0d level=%0d", edge_n, prio_enc(therm_out), level);
            end
            checks++;
            if ($countones(prev ^ therm_out) > 1) begin
                errors++;
                $display("FAIL rand_single_bit edge %0d prev=%h now=%h", edge_n, prev, therm_out);
            end
            prev = therm_out;
        end
        code_valid = 1'b0;
    endtask

    initial begin
        #12 rst = 1'b0;
        model_reset();
        test_reset();
        test_up_step();
        test_down_step();
        test_held_valid();
        test_reset_mid_step();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
